// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the RAM arbiter between the instruction-fetch
// unit and the load/store (MAR/MDR) unit.
//   state_t    : arbiter sequencing states IDLE -> ACCESS -> RESP
//   port_t     : requester identity (fetch or load/store)
//   MEM_DEPTH  : number of words in the shared RAM
//   other_port : the requester that is not the given one (round-robin helper)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_LS    = 1'b1
    } port_t;

    localparam int MEM_DEPTH = 512;

    function automatic port_t other_port(input port_t p);
        return (p == PORT_FETCH) ? PORT_LS : PORT_FETCH;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// -----------------------------------------------------------------------------
// mem_arb_picker
// Combinational two-way round-robin select between the fetch and load/store
// requesters.
//   if_req      in  fetch request
//   ls_req      in  load/store request
//   last_grant  in  port granted by the previous access
//   grant_valid out at least one request is present
//   grant_id    out winning port (only meaningful when grant_valid is high)
// -----------------------------------------------------------------------------
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic  if_req,
    input  logic  ls_req,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant_id
);

    always_comb begin
        grant_valid = if_req | ls_req;
        grant_id    = PORT_FETCH;
        if (if_req && ls_req) begin
            // Contention: hand the RAM to whoever did not have it last.
            grant_id = other_port(last_grant);
        end else if (ls_req) begin
            grant_id = PORT_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises fetch and load/store accesses onto a shared single-port RAM with
// a fixed three-cycle cadence (IDLE -> ACCESS -> RESP). One access is in flight
// at a time; RAM strobes last exactly one cycle, read data is registered per
// port and each access returns a one-cycle acknowledge.
//
// Optional feature, enabled by defining MEM_ARB_BOUNDS_EN:
//   accesses whose address is >= DEPTH never strobe the RAM; they still ack on
//   schedule, return zero read data, and raise ls_err on the load/store port.
//   Without the macro no check is made and ls_err stays 0.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request and address (held until if_ack)
//   if_ack/if_rdata            fetch completion pulse and instruction word
//   ls_req/ls_we/ls_addr/
//   ls_wdata                   load/store request (held until ls_ack)
//   ls_ack/ls_rdata/ls_err     load/store completion pulse, load data, error
//   busy                       access in flight (ACCESS or RESP)
//   ram_address/ram_data_in/
//   ram_read/ram_write         registered RAM controls
//   ram_data_out               RAM read data (combinational from address)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_data_out
);

`ifdef MEM_ARB_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t            state;
    port_t             last_grant;
    port_t             cur_port;
    logic              cur_we;
    logic              cur_oob;

    logic              grant_valid;
    port_t             grant_id;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_oob;

    mem_arb_picker u_picker (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Request fields of the winning port, latched on the IDLE -> ACCESS edge.
    always_comb begin
        sel_addr = if_addr;
        sel_we   = 1'b0;
        if (grant_id == PORT_LS) begin
            sel_addr = ls_addr;
            sel_we   = ls_we;
        end
        // With the check disabled this folds to 0 and the address goes to RAM as is.
        sel_oob = BOUNDS_EN && (64'(sel_addr) >= 64'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= PORT_FETCH;
            cur_port    <= PORT_FETCH;
            cur_we      <= 1'b0;
            cur_oob     <= 1'b0;
            if_ack      <= 1'b0;
            ls_ack      <= 1'b0;
            ls_err      <= 1'b0;
            busy        <= 1'b0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            if_rdata    <= '0;
            ls_rdata    <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
        end else begin
            case (state)
                // IDLE: pick a winner and launch its strobe for the ACCESS cycle.
                IDLE: begin
                    if (grant_valid) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        last_grant  <= grant_id;
                        cur_port    <= grant_id;
                        cur_we      <= sel_we;
                        cur_oob     <= sel_oob;
                        ram_address <= sel_addr;
                        ram_read    <= !sel_we && !sel_oob;
                        ram_write   <= sel_we && !sel_oob;
                        if (sel_we) begin
                            ram_data_in <= ls_wdata;
                        end
                    end
                end

                // ACCESS: RAM sees the strobe; capture read data into the port's register.
                ACCESS: begin
                    state     <= RESP;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    if (cur_port == PORT_LS) begin
                        ls_ack <= 1'b1;
                        ls_err <= cur_oob;
                        if (!cur_we) begin
                            ls_rdata <= cur_oob ? '0 : ram_data_out;
                        end
                    end else begin
                        if_ack   <= 1'b1;
                        // A zero word decodes as an illegal opcode, never as a nop.
                        if_rdata <= cur_oob ? '0 : ram_data_out;
                    end
                end

                // RESP: ack is visible this cycle; address stays put.
                RESP: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    if_ack <= 1'b0;
                    ls_ack <= 1'b0;
                    ls_err <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    if_ack    <= 1'b0;
                    ls_ack    <= 1'b0;
                    ls_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter: a behavioural RAM, a transaction-level reference model
// (shadow memory, expected grant order and ack timing), directed scenarios and
// a randomized traffic phase. Honours MEM_ARB_BOUNDS_EN like the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 512;
`ifdef MEM_ARB_BOUNDS_EN
    localparam int ADDR_SPAN = 700;
`else
    localparam int ADDR_SPAN = DEPTH;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;
    logic              busy;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] ram_data_out;

    mem_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_ack       (ls_ack),
        .ls_rdata     (ls_rdata),
        .ls_err       (ls_err),
        .busy         (busy),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with a preload path.
    logic [31:0] mem [DEPTH];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (ram_write) mem[ram_address[8:0]] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_address[8:0]];

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          have_dec = 0;
    int          dec_cyc = 0;
    bit          dec_ls, dec_we, dec_oob;
    int unsigned dec_addr;
    logic [31:0] dec_wdata;
    bit          last_ls = 0;
    logic [31:0] if_last = '0, ls_last = '0;
    logic [31:0] exp_ram_addr = '0;
    bit          reset_chk = 0;
    bit          if_pend = 0, ls_pend = 0, ls_pwe = 0;
    int unsigned if_pa = 0, ls_pa = 0;
    logic [31:0] ls_pd = '0;
    int          req_pct = 0;
    bit          served[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic issue_if(input int unsigned a);
        if_pend = 1; if_pa = a;
    endtask

    task automatic issue_ls(input bit we, input int unsigned a, input logic [31:0] d);
        ls_pend = 1; ls_pwe = we; ls_pa = a; ls_pd = d;
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    // and drive the requests the DUT samples at the next rising edge.
    task automatic step(input bit rst_now);
        bit acc_cyc, ack_cyc;
        @(negedge clk);
        cyc++;
        acc_cyc = have_dec && (cyc == dec_cyc + 1);
        ack_cyc = have_dec && (cyc == dec_cyc + 2);
        if (ls_ack === 1'b1) served.push_back(1'b1);
        if (if_ack === 1'b1) served.push_back(1'b0);
        chk("if_ack", if_ack, ack_cyc && !dec_ls);
        chk("ls_ack", ls_ack, ack_cyc && dec_ls);
        chk("busy", busy, acc_cyc || ack_cyc);
        chk("ram_read", ram_read, acc_cyc && !dec_we && !dec_oob);
        chk("ram_write", ram_write, acc_cyc && dec_we && !dec_oob);
        if (acc_cyc && dec_we && !dec_oob) chk("ram_data_in", ram_data_in, dec_wdata);
        if (ack_cyc) begin
            if (dec_ls) begin
                if (dec_we) begin
                    if (!dec_oob) ref_mem[dec_addr] = dec_wdata;
                end else if (dec_oob) ls_last = '0;
                else ls_last = ref_mem[dec_addr];
                chk("ls_err", ls_err, dec_oob);
                ls_pend = 0;
            end else begin
                if (dec_oob) if_last = '0;
                else if_last = ref_mem[dec_addr];
                if_pend = 0;
            end
        end
        chk("if_rdata", if_rdata, if_last);
        chk("ls_rdata", ls_rdata, ls_last);
        chk("ram_address", ram_address, exp_ram_addr);
        if (reset_chk) begin
            chk("rst_ls_err", ls_err, 0);
            chk("rst_data_in", ram_data_in, 0);
            reset_chk = 0;
        end
        reset = rst_now;
        if (rst_now) begin
            have_dec = 0; last_ls = 0; if_last = '0; ls_last = '0;
            exp_ram_addr = '0; reset_chk = 1;
        end else begin
            if (!if_pend && $urandom_range(99) < req_pct) issue_if($urandom_range(ADDR_SPAN - 1));
            if (!ls_pend && $urandom_range(99) < req_pct)
                issue_ls(1'($urandom_range(1)), $urandom_range(ADDR_SPAN - 1), $urandom);
            if ((!have_dec || cyc >= dec_cyc + 3) && (if_pend || ls_pend)) begin
                dec_ls    = ls_pend && (!if_pend || !last_ls);
                last_ls   = dec_ls;
                have_dec  = 1;
                dec_cyc   = cyc;
                dec_addr  = dec_ls ? ls_pa : if_pa;
                dec_we    = dec_ls && ls_pwe;
                dec_wdata = ls_pd;
                dec_oob   = (dec_addr >= DEPTH);
                exp_ram_addr = dec_addr;
            end
        end
        if_req   = if_pend;
        if_addr  = if_pa;
        ls_req   = ls_pend;
        ls_we    = ls_pwe;
        ls_addr  = ls_pa;
        ls_wdata = ls_pd;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (if_pend || ls_pend || (have_dec && cyc < dec_cyc + 3)); i++) step(0);
        chk("drain", {if_pend, ls_pend}, 2'b00);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        @(negedge clk);
        pl_en = 1;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            if (i == 71) v = 32'h94;
            ref_mem[i] = v;
            pl_idx = 9'(i);
            pl_val = v;
            @(negedge clk);
        end
        pl_en = 0;
        @(negedge clk);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_ls_ack", ls_ack, 0);
        chk("rst_ls_err", ls_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ram_read", ram_read, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        reset = 0;

        // Load from word 0x47.
        issue_ls(0, 32'h47, '0);
        repeat (4) step(0);
        chk("t1_ls_rdata", ls_rdata, 32'h94);

        // Store then load back at 0x8E.
        issue_ls(1, 32'h8E, 32'd9);
        repeat (4) step(0);
        issue_ls(0, 32'h8E, '0);
        repeat (4) step(0);
        chk("t2_ls_rdata", ls_rdata, 32'd9);

        // Simultaneous requests straight after reset: LS first, then fetch.
        step(1);
        issue_if(0);
        issue_ls(0, 32'h47, '0);
        repeat (7) step(0);
        chk("t3_if_rdata", if_rdata, ref_mem[0]);
        chk("t3_order", served.size() >= 2 ? {served[served.size()-2], served[served.size()-1]} : 2'b11, 2'b10);

        // Both ports held continuously: grants must alternate.
        drain();
        served.delete();
        req_pct = 100;
        repeat (12) step(0);
        req_pct = 0;
        drain();
        chk("t4_count", served.size() >= 4, 1);
        for (int i = 1; i < served.size(); i++) chk("t4_alt", served[i], !served[i-1]);

        // Reset during the ACCESS cycle of a load; request stays held.
        issue_ls(0, 32'h8E, '0);
        step(0);
        step(1);
        repeat (4) step(0);
        chk("t5_ls_rdata", ls_rdata, 32'd9);

`ifdef MEM_ARB_BOUNDS_EN
        // Out-of-range store and load.
        issue_ls(1, 600, 32'hDEAD_BEEF);
        repeat (4) step(0);
        issue_ls(0, 600, '0);
        repeat (4) step(0);
        chk("t6_ls_rdata", ls_rdata, 0);
        issue_if(600);
        repeat (4) step(0);
        chk("t6_if_rdata", if_rdata, 0);
`endif

        // Randomized mixed traffic.
        req_pct = 30;
        repeat (3000) step(0);
        req_pct = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
